// File: rtl/psola_readout.sv
// PSOLA output-buffer playback: reads 0..len-1 and rescales/saturates each word to 16-bit PCM, one sample per tick.
// Optional post-read zeroing of each buffer word is enabled by defining PSOLA_READOUT_CLEAR_EN.
module psola_readout #(
  parameter int WINDOW_SIZE = 2048,
  parameter int FRAC_BITS   = 10,
  localparam int LOG_WINDOW_SIZE = $clog2(WINDOW_SIZE),
  localparam int AW = LOG_WINDOW_SIZE + 1
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic [11:0]   window_len_in,
  input  logic          window_len_valid_in,
  input  logic          sample_tick_in,
  output logic [AW-1:0] rd_addr_out,
  input  logic [31:0]   rd_data_in,
  output logic [AW-1:0] clr_addr_out,
  output logic          clr_en_out,
  output logic [15:0]   sample_out,
  output logic          sample_valid_out,
  output logic          busy_out,
  output logic          done_out,
  output logic          underrun_out,
  output logic          overrun_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // BRAM read latency is two cycles, so the capture happens when this counter reaches zero.
  localparam logic [1:0] FETCH_WAIT = 2'd2;

  state_e        state_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    wait_q;
  logic [15:0]   held_q;
  logic [AW-1:0] rd_addr_q;
  logic [15:0]   sample_q;
  logic          sample_valid_q;
  logic          busy_q;
  logic          done_q;
  logic          underrun_q;
  logic          overrun_q;
`ifdef PSOLA_READOUT_CLEAR_EN
  logic [AW-1:0] clr_addr_q;
  logic          clr_en_q;
`endif

  logic [AW-1:0]      len_d;
  logic [AW-1:0]      idx_inc_d;
  logic signed [31:0] shifted_d;
  logic [15:0]        sample_d;

  always_comb begin
    if ({20'd0, window_len_in} > 32'(WINDOW_SIZE)) begin
      len_d = AW'(WINDOW_SIZE);
    end else begin
      len_d = AW'(window_len_in);
    end
  end

  assign idx_inc_d = idx_q + AW'(1);
  assign shifted_d = $signed(rd_data_in) >>> FRAC_BITS;

  always_comb begin
    if (shifted_d > 32'sd32767) begin
      sample_d = 16'h7fff;
    end else if (shifted_d < -32'sd32768) begin
      sample_d = 16'h8000;
    end else begin
      sample_d = shifted_d[15:0];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      idx_q          <= '0;
      wait_q         <= '0;
      held_q         <= '0;
      rd_addr_q      <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef PSOLA_READOUT_CLEAR_EN
      clr_addr_q     <= '0;
      clr_en_q       <= 1'b0;
`endif
    end else begin
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
`ifdef PSOLA_READOUT_CLEAR_EN
      clr_en_q       <= 1'b0;
`endif
      // Every tick produces an output; only READY has a real sample, the rest is silence.
      if (sample_tick_in) begin
        sample_valid_q <= 1'b1;
        sample_q       <= (state_q == ST_READY) ? held_q : 16'h0000;
      end

      case (state_q)
        ST_IDLE: begin
          if (window_len_valid_in) begin
            len_q      <= len_d;
            idx_q      <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            if (len_d == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= ST_FETCH;
              busy_q    <= 1'b1;
              rd_addr_q <= '0;
              wait_q    <= FETCH_WAIT;
            end
          end
        end

        ST_FETCH: begin
          if (window_len_valid_in) overrun_q <= 1'b1;
          if (sample_tick_in) underrun_q <= 1'b1;
`ifdef PSOLA_READOUT_CLEAR_EN
          if (wait_q == 2'd1) begin
            clr_en_q   <= 1'b1;
            clr_addr_q <= idx_q;
          end
`endif
          if (wait_q == 2'd0) begin
            held_q  <= sample_d;
            state_q <= ST_READY;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end

        ST_READY: begin
          if (window_len_valid_in) overrun_q <= 1'b1;
          if (sample_tick_in) begin
            if (idx_inc_d < len_q) begin
              idx_q     <= idx_inc_d;
              rd_addr_q <= idx_inc_d;
              wait_q    <= FETCH_WAIT;
              state_q   <= ST_FETCH;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_addr_out      = rd_addr_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = sample_valid_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;
  assign underrun_out     = underrun_q;
  assign overrun_out      = overrun_q;
`ifdef PSOLA_READOUT_CLEAR_EN
  assign clr_addr_out     = clr_addr_q;
  assign clr_en_out       = clr_en_q;
`else
  assign clr_addr_out     = '0;
  assign clr_en_out       = 1'b0;
`endif

endmodule

// File: doc/psola_readout.md
# psola_readout

Playback end of the PSOLA output buffer. After `psola` finishes overlap-adding a window into the processed-sample BRAM and pulses its window-length valid, this block reads the buffer back in address order 0..len-1. Each word is a signed Q10-weighted accumulation; the block rescales and saturates it to a 16-bit PCM sample and emits one sample per output-rate tick. Optionally it zeroes each location after reading, so the next overlap-add pass starts from a clean buffer.

## Interface

- `WINDOW_SIZE`, 2048: buffer depth in words; `LOG_WINDOW_SIZE = $clog2(WINDOW_SIZE)`.
- `FRAC_BITS`, 10: fractional bits of buffer words; shift-right amount applied before saturation.
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `window_len_in`  in  12  number of valid words in the buffer; sampled only on `window_len_valid_in`.
- `window_len_valid_in`  in  1  one-cycle start pulse from `psola`.
- `sample_tick_in`  in  1  one-cycle output-rate strobe (e.g. 48 kHz).
- `rd_addr_out`  out  LOG_WINDOW_SIZE+1  BRAM read address (registered).
- `rd_data_in`  in  32  BRAM data for `rd_addr_out`, presented 2 cycles earlier.
- `clr_addr_out`  out  LOG_WINDOW_SIZE+1  BRAM clear-write address.
- `clr_en_out`  out  1  write-zero strobe.
- `sample_out`  out  16  signed PCM sample.
- `sample_valid_out`  out  1  one-cycle pulse per tick.
- `busy_out`  out  1  high from accepted start until the done cycle.
- `done_out`  out  1  one-cycle pulse after the last sample is emitted.
- `underrun_out`  out  1  sticky; set when a tick arrives in FETCH; cleared only by reset or an accepted start.
- `overrun_out`  out  1  sticky; set when a start pulse arrives while busy; same clear rule.

## Operation

- States: IDLE, FETCH, READY.
- All outputs reset to 0. `idx` and the held sample reset to 0. State resets to IDLE.
- IDLE + start:
  - latch `len = min(window_len_in, WINDOW_SIZE)`; set `idx = 0`; clear both sticky flags.
  - if `len == 0`, pulse `done_out` next cycle and stay IDLE.
  - otherwise go to FETCH.
- FETCH:
  - drive `rd_addr_out = idx`.
  - 2 cycles later, capture `rd_data_in` and go to READY.
- Capture arithmetic:
  - `s = $signed(rd_data_in) >>> FRAC_BITS` (arithmetic shift).
  - saturate to [-32768, 32767].
- READY + tick:
  - emit held sample.
  - if `idx + 1 < len`: `idx++` and go to FETCH.
  - else: pulse `done_out`, drop `busy_out`, go to IDLE.
- Tick in IDLE: emit `sample_out = 0` with a valid pulse (silence). No flag is set.
- Tick in FETCH: emit `sample_out = 0` with a valid pulse and set `underrun_out`. The fetch continues; the sample is held for the next tick.
- Start while busy (FETCH/READY): ignored, set `overrun_out`.
- Start and tick in the same cycle in IDLE: the tick emits silence and the start is accepted.
- Reset mid-operation: returns immediately to IDLE with all outputs 0. Any pending clear write is dropped.

## Timing

- Start accepted at cycle 0:
  - `busy_out` high and `rd_addr_out = 0` from cycle 1.
  - data captured at the cycle-3 edge; READY from cycle 4.
- Tick in READY at cycle T:
  - `sample_out` and `sample_valid_out` valid during T+1 only.
  - next `rd_addr_out` at T+1; READY again at T+4.
- Tick spacing must be at least 4 cycles to avoid underrun.
- `done_out` is asserted at T+1 of the final tick, coincident with the last `sample_valid_out`.
- `sample_out` holds its value between pulses.

## Configuration

- `PSOLA_READOUT_CLEAR_EN` defined:
  - in the capture cycle, pulse `clr_en_out` with `clr_addr_out = idx`; the BRAM writes 32'h0.
  - one clear per word read; none on reset abort.
- Not defined: `clr_en_out` and `clr_addr_out` are tied to 0, and the buffer is left intact.

## Test plan

- BRAM model preloaded with `{5<<10, -3<<10, 1<<9}`; start with len=3; ticks every 100 cycles -> samples 5, -3, 0 (1<<9 >>> 10 = 0); `done_out` pulses with the 3rd sample.
- Buffer words 32'h7FFF_FFFF and 32'h8000_0000 -> samples 32767 and -32768.
- Ticks 2 cycles apart after start -> first tick emits 0, `underrun_out` = 1; the following tick emits the correct sample.
- Start with len=0 -> `done_out` at cycle 1, no read, `busy_out` stays 0; start with len=4000 -> exactly 2048 samples emitted.
- Second start mid-window -> `overrun_out` = 1, current window completes unchanged; with `PSOLA_READOUT_CLEAR_EN`, every address 0..len-1 reads back 0 afterward.
- `rst_n_in` low during READY -> all outputs 0 asynchronously; after release, a tick emits silence and a new start runs normally.
